// File: rtl/pio_input_pkg.sv
// Shared field offsets and debounce state encoding for the PIO input conditioner.
package pio_input_pkg;

  localparam int unsigned BTN_LEVEL_LSB  = 0;
  localparam int unsigned BTN_STICKY_LSB = 8;
  localparam int unsigned BTN_COUNT_LSB  = 16;
  localparam int unsigned BTN_COUNT_W    = 8;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-flop synchronizer, polarity normalization and debounce FSM.
// RESET_VAL is the raw released level; XOR with it makes "active" read as 1.
module debounce_channel
  import pio_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  assign level = sync_q[1] ^ RESET_VAL;

  // State register, synchronizer and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {2{RESET_VAL}};
      state_q <= STABLE;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  // Next state: any sample matching deb during COUNTING restarts the wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    unique case (state_q)
      STABLE: begin
        if (level != deb_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNTING: begin
        if (level == deb_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          deb_d   = level;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Rise pulse is asserted in the cycle before deb goes high, so consumers
  // registering it update on the same edge as deb.
  always_comb begin
    rise_c = (state_q == COUNTING) && (cnt_q == CNT_LAST) && level && !deb_q;
  end

  assign deb = deb_q;

endmodule

// File: rtl/pio_input_conditioner.sv
// Debounces board buttons/switches and packs them into the two host input PIO words.
module pio_input_conditioner
  import pio_input_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned N_SW            = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic             ack,
  output logic [31:0]      buttons_word,
  output logic [31:0]      switches_word
);

  if (N_BTN < 1 || N_BTN > 8) begin : g_bad_n_btn
    $error("pio_input_conditioner: N_BTN must be 1..8");
  end
  if (N_SW < 1 || N_SW > 32) begin : g_bad_n_sw
    $error("pio_input_conditioner: N_SW must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("pio_input_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [N_BTN-1:0]       btn_deb;
  logic [N_BTN-1:0]       press_c;
  logic [N_SW-1:0]        sw_deb;
  logic [N_SW-1:0]        sw_rise_unused;
  logic [1:0]             ack_sync_q;
  logic                   ack_q;
  logic                   ack_rise_q;
  logic [N_BTN-1:0]       sticky_q;
  logic [BTN_COUNT_W-1:0] count_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (BTN_ACTIVE_LOW)
    ) u_deb (
      .clk   (clk),
      .rst   (reset),
      .raw   (btn_raw[i]),
      .deb   (btn_deb[i]),
      .rise_c(press_c[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_deb (
      .clk   (clk),
      .rst   (reset),
      .raw   (sw_raw[i]),
      .deb   (sw_deb[i]),
      .rise_c(sw_rise_unused[i])
    );
  end

  // Ack edge detect, sticky flags (set beats clear) and press counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_sync_q <= '0;
      ack_q      <= 1'b0;
      ack_rise_q <= 1'b0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[0], ack};
      ack_q      <= ack_sync_q[1];
      ack_rise_q <= ack_sync_q[1] & ~ack_q;
      sticky_q   <= (ack_rise_q ? '0 : sticky_q) | press_c;
      if (|press_c) begin
        count_q <= count_q + BTN_COUNT_W'(1);
      end
    end
  end

  // Word fields are flop outputs wired straight onto the ports
  always_comb begin
    buttons_word                                  = '0;
    buttons_word[BTN_LEVEL_LSB +: N_BTN]          = btn_deb;
    buttons_word[BTN_STICKY_LSB +: N_BTN]         = sticky_q;
    buttons_word[BTN_COUNT_LSB +: BTN_COUNT_W]    = count_q;
    switches_word                                 = '0;
    switches_word[N_SW-1:0]                       = sw_deb;
  end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Self-checking bench for pio_input_conditioner with a sample-history reference model.
module tb_pio_input_conditioner;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_raw = 4'hF;
  logic [17:0] sw_raw = '0;
  logic        ack = 1'b0;
  logic [31:0] buttons_word;
  logic [31:0] switches_word;

  int vectors = 0;
  int miscompares = 0;

  pio_input_conditioner #(
    .N_BTN(4),
    .N_SW(18),
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .ack(ack),
    .buttons_word(buttons_word),
    .switches_word(switches_word)
  );

  always #5 clk = ~clk;

  // Reference model: each debouncer sees the pin as sampled two edges earlier
  // and accepts a new level after D consecutive differing samples.
  logic [3:0]  mb_d1, mb_d2, mb_deb;
  logic [17:0] ms_d1, ms_d2, ms_deb;
  int          mb_run[4];
  int          ms_run[18];
  logic [3:0]  ack_hist;
  logic [3:0]  m_sticky;
  logic [7:0]  m_count;
  logic [31:0] exp_btn, exp_sw;

  always @(posedge clk or posedge reset) begin : model
    logic [3:0] press;
    logic       clr;
    if (reset) begin
      mb_d1 = '0; mb_d2 = '0; mb_deb = '0;
      ms_d1 = '0; ms_d2 = '0; ms_deb = '0;
      foreach (mb_run[i]) mb_run[i] = 0;
      foreach (ms_run[i]) ms_run[i] = 0;
      ack_hist = '0; m_sticky = '0; m_count = '0;
    end else begin
      press = '0;
      for (int i = 0; i < 4; i++) begin
        if (mb_d2[i] != mb_deb[i]) begin
          mb_run[i]++;
          if (mb_run[i] == D) begin
            mb_deb[i] = mb_d2[i];
            mb_run[i] = 0;
            press[i]  = mb_deb[i];
          end
        end else mb_run[i] = 0;
      end
      for (int i = 0; i < 18; i++) begin
        if (ms_d2[i] != ms_deb[i]) begin
          ms_run[i]++;
          if (ms_run[i] == D) begin
            ms_deb[i] = ms_d2[i];
            ms_run[i] = 0;
          end
        end else ms_run[i] = 0;
      end
      mb_d2 = mb_d1; mb_d1 = ~btn_raw;
      ms_d2 = ms_d1; ms_d1 = sw_raw;
      // ack sampled 3 edges ago high and 4 edges ago low -> clear on this edge
      clr = ack_hist[2] & ~ack_hist[3];
      ack_hist = {ack_hist[2:0], ack};
      m_sticky = (clr ? 4'h0 : m_sticky) | press;
      if (press != 4'h0) m_count = m_count + 8'd1;
    end
    exp_btn = {8'h00, m_count, 4'h0, m_sticky, 4'h0, mb_deb};
    exp_sw  = {14'h0, ms_deb};
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (buttons_word !== 32'h0 || switches_word !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h/%h expected 00000000/00000000", buttons_word, switches_word);
    end
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      vectors++;
      if (buttons_word !== 32'h0 || switches_word !== 32'h0 ||
          buttons_word !== exp_btn || switches_word !== exp_sw) begin
        miscompares++;
        $display("FAIL reset_idle c%0d: got %h/%h expected 00000000/00000000", c, buttons_word, switches_word);
      end
    end
  endtask

  task automatic test_press_release();
    logic [31:0] want;
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      want = (c < 6) ? 32'h0 : 32'h00010101;
      vectors++;
      if (buttons_word !== want || buttons_word !== exp_btn) begin
        miscompares++;
        $display("FAIL press c%0d: got %h expected %h model %h", c, buttons_word, want, exp_btn);
      end
    end
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      want = (c < 6) ? 32'h00010101 : 32'h00010100;
      vectors++;
      if (buttons_word !== want || buttons_word !== exp_btn) begin
        miscompares++;
        $display("FAIL release c%0d: got %h expected %h model %h", c, buttons_word, want, exp_btn);
      end
    end
  endtask

  task automatic test_glitch();
    btn_raw[2] = 1'b0;
    repeat (3) @(negedge clk);
    btn_raw[2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (buttons_word !== 32'h00010100 || buttons_word !== exp_btn) begin
        miscompares++;
        $display("FAIL glitch c%0d: got %h expected 00010100", c, buttons_word);
      end
    end
  endtask

  task automatic test_ack();
    logic [3:0] want_sticky;
    btn_raw[2] = 1'b0;
    repeat (7) @(negedge clk);
    btn_raw[2] = 1'b1;
    repeat (7) @(negedge clk);
    vectors++;
    if (buttons_word !== 32'h00020500) begin
      miscompares++;
      $display("FAIL ack_setup: got %h expected 00020500", buttons_word);
    end
    ack = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 6) btn_raw[1] = 1'b0;
      if (c == 13) btn_raw[1] = 1'b1;
      want_sticky = (c < 4) ? 4'h5 : (c < 12 ? 4'h0 : 4'h2);
      vectors++;
      if (buttons_word[11:8] !== want_sticky || buttons_word !== exp_btn) begin
        miscompares++;
        $display("FAIL ack_clear c%0d: got %h sticky %h expected sticky %h", c, buttons_word, buttons_word[11:8], want_sticky);
      end
    end
    ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (buttons_word !== 32'h00030200 || buttons_word !== exp_btn) begin
        miscompares++;
        $display("FAIL ack_hold c%0d: got %h expected 00030200", c, buttons_word);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] want;
    btn_raw[0] = 1'b0;
    repeat (7) @(negedge clk);
    btn_raw[0] = 1'b1;
    repeat (7) @(negedge clk);
    btn_raw[3] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) ack = 1'b1;
      want = (c < 6) ? 32'h00040300 : 32'h00050808;
      vectors++;
      if (buttons_word !== want || buttons_word !== exp_btn) begin
        miscompares++;
        $display("FAIL simul c%0d: got %h expected %h", c, buttons_word, want);
      end
    end
    btn_raw[3] = 1'b1;
    ack = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (buttons_word !== 32'h00050800 || buttons_word !== exp_btn) begin
      miscompares++;
      $display("FAIL simul_end: got %h expected 00050800", buttons_word);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 256; k++) begin
      btn_raw[1] = 1'b0;
      repeat ($urandom_range(5, 9)) begin
        @(negedge clk);
        vectors++;
        if (buttons_word !== exp_btn) begin
          miscompares++;
          $display("FAIL wrap_lo k%0d: got %h expected %h", k, buttons_word, exp_btn);
        end
      end
      btn_raw[1] = 1'b1;
      repeat ($urandom_range(5, 9)) begin
        @(negedge clk);
        vectors++;
        if (buttons_word !== exp_btn) begin
          miscompares++;
          $display("FAIL wrap_hi k%0d: got %h expected %h", k, buttons_word, exp_btn);
        end
      end
      if (k == 254) begin
        vectors++;
        if (buttons_word[23:16] !== 8'hFF) begin
          miscompares++;
          $display("FAIL wrap_255: got count %h expected ff", buttons_word[23:16]);
        end
      end
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (buttons_word !== 32'h00000200) begin
      miscompares++;
      $display("FAIL wrap_end: got %h expected 00000200", buttons_word);
    end
  endtask

  task automatic test_switches();
    logic [31:0] want;
    sw_raw = 18'h2AAAA;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      want = (c < 6) ? 32'h0 : 32'h0002AAAA;
      vectors++;
      if (switches_word !== want || switches_word !== exp_sw) begin
        miscompares++;
        $display("FAIL switches c%0d: got %h expected %h", c, switches_word, want);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      vectors++;
      if (buttons_word !== exp_btn || switches_word !== exp_sw) begin
        miscompares++;
        $display("FAIL random c%0d: got %h/%h expected %h/%h", c, buttons_word, switches_word, exp_btn, exp_sw);
      end
      if ($urandom_range(0, 3) == 0) btn_raw = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sw_raw = 18'($urandom);
      if ($urandom_range(0, 15) == 0) ack = ~ack;
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 4'hF; sw_raw = '0; ack = 1'b0;
    repeat (10) @(negedge clk);
    btn_raw[0] = 1'b0;
    sw_raw = 18'h3FFFF;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (buttons_word !== 32'h0 || switches_word !== 32'h0 ||
        buttons_word !== exp_btn || switches_word !== exp_sw) begin
      miscompares++;
      $display("FAIL reset_mid: got %h/%h expected 00000000/00000000", buttons_word, switches_word);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      vectors++;
      if (buttons_word !== exp_btn || switches_word !== exp_sw) begin
        miscompares++;
        $display("FAIL reset_resume c%0d: got %h/%h expected %h/%h", c, buttons_word, switches_word, exp_btn, exp_sw);
      end
    end
    vectors++;
    if (buttons_word !== 32'h00010101 || switches_word !== 32'h0003FFFF) begin
      miscompares++;
      $display("FAIL reset_repress: got %h/%h expected 00010101/0003ffff", buttons_word, switches_word);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_press_release();
    test_glitch();
    test_ack();
    test_simultaneous();
    test_wrap();
    test_switches();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
